// File: rtl/cat_trap_pkg.sv
// -----------------------------------------------------------------------------
// cat_trap_pkg
// Items shared by the Cat Trap game sequencer and the VGA renderer:
//   - game_state_t : one-hot game FSM encodings
//   - GRID_N       : board dimension (8x8)
//   - WHITE/GRAY/ORANGE : RGB332 colours for free cells, blocked cells, the cat
//   - cell_idx()   : flat board index row*8+col
//   - edge_dist()  : distance from a cell to the nearest board edge
// -----------------------------------------------------------------------------
package cat_trap_pkg;

  localparam int GRID_N = 8;

  typedef enum logic [4:0] {
    S_START    = 5'b00001,
    S_PLAY     = 5'b00010,
    S_GAMEOVER = 5'b00100,
    S_GAMEWIN  = 5'b01000,
    S_CAT_MOVE = 5'b10000
  } game_state_t;

  localparam logic [7:0] WHITE  = 8'hFF;
  localparam logic [7:0] GRAY   = 8'h92;
  localparam logic [7:0] ORANGE = 8'hF0;

  // With an 8-wide board, row*8+col is simply the row bits above the col bits.
  function automatic logic [5:0] cell_idx(input logic [2:0] row, input logic [2:0] col);
    return {row, col};
  endfunction

  // min(r, c, 7-r, 7-c); 0 means the cell lies on the outer ring.
  function automatic logic [2:0] edge_dist(input logic [2:0] row, input logic [2:0] col);
    logic [2:0] d;
    logic [2:0] rInv;
    logic [2:0] cInv;
    rInv = 3'd7 - row;
    cInv = 3'd7 - col;
    d = row;
    if (col < d)  d = col;
    if (rInv < d) d = rInv;
    if (cInv < d) d = cInv;
    return d;
  endfunction

endpackage

// File: rtl/cat_trap_ctrl_cat_move_sel.sv
// -----------------------------------------------------------------------------
// cat_move_sel
// Purely combinational choice of the cat's next step.
// Ports:
//   blocked  in  64  board mask, bit row*8+col set = blocked
//   cat_row  in  3   current cat row
//   cat_col  in  3   current cat column
//   trapped  out 1   cat is off the edge and every neighbour is blocked
//   escaped  out 1   cat already sits on the outer ring
//   next_row out 3   row of the chosen neighbour (cat_row if no move)
//   next_col out 3   column of the chosen neighbour (cat_col if no move)
// -----------------------------------------------------------------------------
module cat_move_sel
  import cat_trap_pkg::*;
(
  input  logic [63:0] blocked,
  input  logic [2:0]  cat_row,
  input  logic [2:0]  cat_col,
  output logic        trapped,
  output logic        escaped,
  output logic [2:0]  next_row,
  output logic [2:0]  next_col
);

  localparam logic [2:0] MAX_POS = 3'(GRID_N - 1);

  logic [3:0][2:0] w_nr;
  logic [3:0][2:0] w_nc;
  logic            w_found;
  logic [2:0]      w_best_d;
  logic [2:0]      w_d;

  // Neighbours are scanned Up, Right, Down, Left. A strict "<" keeps the
  // earliest candidate on a distance tie. When the cat is on the edge the
  // neighbour indices may wrap, but the result is discarded in that case.
  always_comb begin
    w_nr[0] = cat_row - 3'd1; w_nc[0] = cat_col;
    w_nr[1] = cat_row;        w_nc[1] = cat_col + 3'd1;
    w_nr[2] = cat_row + 3'd1; w_nc[2] = cat_col;
    w_nr[3] = cat_row;        w_nc[3] = cat_col - 3'd1;

    escaped  = (cat_row == 3'd0) || (cat_row == MAX_POS) ||
               (cat_col == 3'd0) || (cat_col == MAX_POS);
    w_found  = 1'b0;
    w_best_d = 3'd7;
    w_d      = 3'd0;
    next_row = cat_row;
    next_col = cat_col;

    for (int k = 0; k < 4; k++) begin
      w_d = edge_dist(w_nr[k], w_nc[k]);
      if (!blocked[cell_idx(w_nr[k], w_nc[k])] && (!w_found || (w_d < w_best_d))) begin
        w_found  = 1'b1;
        w_best_d = w_d;
        next_row = w_nr[k];
        next_col = w_nc[k];
      end
    end

    if (escaped) begin
      next_row = cat_row;
      next_col = cat_col;
    end
    trapped = !escaped && !w_found;
  end

endmodule

// File: rtl/cat_trap_ctrl.sv
// -----------------------------------------------------------------------------
// cat_trap_ctrl
// Game sequencer for the 8x8 Cat Trap board: board mask, cat, cursor, move
// counter and the game FSM. All outputs come straight from registers.
// Parameters:
//   INIT_BLOCKED  cells blocked at game start (bit row*8+col)
//   CAT_R0/CAT_C0 cat start position
// Ports:
//   clk        in  1   system clock
//   reset      in  1   asynchronous active-high reset
//   BtnC       in  1   select/confirm pulse
//   BtnU/D/L/R in  1   cursor movement pulses
//   blocked    out 64  board mask
//   cat_row    out 3   cat row
//   cat_col    out 3   cat column
//   cur_row    out 3   cursor row
//   cur_col    out 3   cursor column
//   game_state out 5   one-hot FSM state
//   move_count out 8   cells blocked by the player this game
// -----------------------------------------------------------------------------
module cat_trap_ctrl
  import cat_trap_pkg::*;
#(
  parameter logic [63:0] INIT_BLOCKED = 64'h0,
  parameter logic [2:0]  CAT_R0       = 3'd3,
  parameter logic [2:0]  CAT_C0       = 3'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        BtnC,
  input  logic        BtnU,
  input  logic        BtnD,
  input  logic        BtnL,
  input  logic        BtnR,
  output logic [63:0] blocked,
  output logic [2:0]  cat_row,
  output logic [2:0]  cat_col,
  output logic [2:0]  cur_row,
  output logic [2:0]  cur_col,
  output logic [4:0]  game_state,
  output logic [7:0]  move_count
);

  localparam logic [2:0] MAX_POS = 3'(GRID_N - 1);

  game_state_t r_state;
  logic [63:0] r_blocked;
  logic [2:0]  r_cat_row;
  logic [2:0]  r_cat_col;
  logic [2:0]  r_cur_row;
  logic [2:0]  r_cur_col;
  logic [7:0]  r_move_count;

  game_state_t w_state_next;
  logic [63:0] w_blocked_next;
  logic [2:0]  w_cat_row_next;
  logic [2:0]  w_cat_col_next;
  logic [2:0]  w_cur_row_next;
  logic [2:0]  w_cur_col_next;
  logic [7:0]  w_move_count_next;

  logic        w_trapped;
  logic        w_escaped;
  logic [2:0]  w_sel_row;
  logic [2:0]  w_sel_col;
  logic [5:0]  w_cur_idx;
  logic        w_cur_on_cat;

  cat_move_sel u_cat_move_sel (
    .blocked  (r_blocked),
    .cat_row  (r_cat_row),
    .cat_col  (r_cat_col),
    .trapped  (w_trapped),
    .escaped  (w_escaped),
    .next_row (w_sel_row),
    .next_col (w_sel_col)
  );

  assign w_cur_idx    = cell_idx(r_cur_row, r_cur_col);
  assign w_cur_on_cat = (r_cur_row == r_cat_row) && (r_cur_col == r_cat_col);

  // State and datapath registers; reset also clears any half-done cat move.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= S_START;
      r_blocked    <= INIT_BLOCKED;
      r_cat_row    <= CAT_R0;
      r_cat_col    <= CAT_C0;
      r_cur_row    <= 3'd0;
      r_cur_col    <= 3'd0;
      r_move_count <= 8'd0;
    end else begin
      r_state      <= w_state_next;
      r_blocked    <= w_blocked_next;
      r_cat_row    <= w_cat_row_next;
      r_cat_col    <= w_cat_col_next;
      r_cur_row    <= w_cur_row_next;
      r_cur_col    <= w_cur_col_next;
      r_move_count <= w_move_count_next;
    end
  end

  // Next-state and datapath updates. The if/else chain on the buttons gives
  // the C > U > D > L > R priority, so only one action happens per cycle.
  always_comb begin
    w_state_next      = r_state;
    w_blocked_next    = r_blocked;
    w_cat_row_next    = r_cat_row;
    w_cat_col_next    = r_cat_col;
    w_cur_row_next    = r_cur_row;
    w_cur_col_next    = r_cur_col;
    w_move_count_next = r_move_count;

    case (r_state)
      S_START: begin
        if (BtnC) w_state_next = S_PLAY;
      end

      S_PLAY: begin
        if (BtnC) begin
          if (!r_blocked[w_cur_idx] && !w_cur_on_cat) begin
            w_blocked_next[w_cur_idx] = 1'b1;
            if (r_move_count != 8'hFF) w_move_count_next = r_move_count + 8'd1;
            w_state_next = S_CAT_MOVE;
          end
        end else if (BtnU) begin
          if (r_cur_row != 3'd0) w_cur_row_next = r_cur_row - 3'd1;
        end else if (BtnD) begin
          if (r_cur_row != MAX_POS) w_cur_row_next = r_cur_row + 3'd1;
        end else if (BtnL) begin
          if (r_cur_col != 3'd0) w_cur_col_next = r_cur_col - 3'd1;
        end else if (BtnR) begin
          if (r_cur_col != MAX_POS) w_cur_col_next = r_cur_col + 3'd1;
        end
      end

      S_CAT_MOVE: begin
        if (w_escaped) begin
          w_state_next = S_GAMEOVER;
        end else if (w_trapped) begin
          w_state_next = S_GAMEWIN;
        end else begin
          w_cat_row_next = w_sel_row;
          w_cat_col_next = w_sel_col;
          w_state_next   = (edge_dist(w_sel_row, w_sel_col) == 3'd0) ? S_GAMEOVER : S_PLAY;
        end
      end

      S_GAMEOVER, S_GAMEWIN: begin
        if (BtnC) begin
          w_state_next      = S_START;
          w_blocked_next    = INIT_BLOCKED;
          w_cat_row_next    = CAT_R0;
          w_cat_col_next    = CAT_C0;
          w_cur_row_next    = 3'd0;
          w_cur_col_next    = 3'd0;
          w_move_count_next = 8'd0;
        end
      end

      default: begin
        w_state_next = S_START;
      end
    endcase
  end

  assign blocked    = r_blocked;
  assign cat_row    = r_cat_row;
  assign cat_col    = r_cat_col;
  assign cur_row    = r_cur_row;
  assign cur_col    = r_cur_col;
  assign game_state = r_state;
  assign move_count = r_move_count;

endmodule

// File: tb/tb_cat_trap_ctrl.sv
// -----------------------------------------------------------------------------
// tb_cat_trap_ctrl
// Directed bench for cat_trap_ctrl. Three instances share clock, reset and
// buttons: dutA uses the defaults, dutW starts with the cat fenced on three
// sides, dutL starts the cat at (1,1). Each scenario checks only the
// instance it was written for.
// -----------------------------------------------------------------------------
module tb_cat_trap_ctrl;

  localparam logic [4:0] ST_START    = 5'b00001;
  localparam logic [4:0] ST_PLAY     = 5'b00010;
  localparam logic [4:0] ST_GAMEOVER = 5'b00100;
  localparam logic [4:0] ST_GAMEWIN  = 5'b01000;
  localparam logic [4:0] ST_CATMOVE  = 5'b10000;

  // Button vectors ordered {C, U, D, L, R}
  localparam logic [4:0] BTN_C = 5'b10000;
  localparam logic [4:0] BTN_U = 5'b01000;
  localparam logic [4:0] BTN_D = 5'b00100;
  localparam logic [4:0] BTN_L = 5'b00010;
  localparam logic [4:0] BTN_R = 5'b00001;

  localparam logic [63:0] INIT_W = (64'h1 << 19) | (64'h1 << 28) | (64'h1 << 35);

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic BtnC = 1'b0, BtnU = 1'b0, BtnD = 1'b0, BtnL = 1'b0, BtnR = 1'b0;

  logic [63:0] aBlocked, wBlocked, lBlocked;
  logic [2:0]  aCatRow, aCatCol, aCurRow, aCurCol;
  logic [2:0]  wCatRow, wCatCol, wCurRow, wCurCol;
  logic [2:0]  lCatRow, lCatCol, lCurRow, lCurCol;
  logic [4:0]  aState, wState, lState;
  logic [7:0]  aMoves, wMoves, lMoves;

  int assertCount = 0;
  int failCount   = 0;

  cat_trap_ctrl dutA (
    .clk(clk), .reset(reset), .BtnC(BtnC), .BtnU(BtnU), .BtnD(BtnD), .BtnL(BtnL), .BtnR(BtnR),
    .blocked(aBlocked), .cat_row(aCatRow), .cat_col(aCatCol), .cur_row(aCurRow),
    .cur_col(aCurCol), .game_state(aState), .move_count(aMoves)
  );

  cat_trap_ctrl #(.INIT_BLOCKED(INIT_W)) dutW (
    .clk(clk), .reset(reset), .BtnC(BtnC), .BtnU(BtnU), .BtnD(BtnD), .BtnL(BtnL), .BtnR(BtnR),
    .blocked(wBlocked), .cat_row(wCatRow), .cat_col(wCatCol), .cur_row(wCurRow),
    .cur_col(wCurCol), .game_state(wState), .move_count(wMoves)
  );

  cat_trap_ctrl #(.CAT_R0(3'd1), .CAT_C0(3'd1)) dutL (
    .clk(clk), .reset(reset), .BtnC(BtnC), .BtnU(BtnU), .BtnD(BtnD), .BtnL(BtnL), .BtnR(BtnR),
    .blocked(lBlocked), .cat_row(lCatRow), .cat_col(lCatCol), .cur_row(lCurRow),
    .cur_col(lCurCol), .game_state(lState), .move_count(lMoves)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    assertCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Buttons are raised on a falling edge, captured by the next rising edge
  // and dropped on the falling edge after, where outputs are then sampled.
  task automatic applyStimulus(input logic [4:0] btns);
    @(negedge clk);
    {BtnC, BtnU, BtnD, BtnL, BtnR} = btns;
    @(negedge clk);
    {BtnC, BtnU, BtnD, BtnL, BtnR} = 5'b00000;
  endtask

  task automatic applyReset();
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic repeatStimulus(input logic [4:0] btns, input int n);
    for (int i = 0; i < n; i++) applyStimulus(btns);
  endtask

  initial begin
    // Reset state
    applyReset();
    checkOutput("reset_state", aState, ST_START);
    checkOutput("reset_blocked", aBlocked, 64'h0);
    checkOutput("reset_cat", {aCatRow, aCatCol}, {3'd3, 3'd3});
    checkOutput("reset_cursor", {aCurRow, aCurCol}, {3'd0, 3'd0});
    checkOutput("reset_moves", aMoves, 8'd0);
    checkOutput("reset_w_blocked", wBlocked, INIT_W);
    checkOutput("reset_l_cat", {lCatRow, lCatCol}, {3'd1, 3'd1});

    // Direction ignored in START, then start the game
    applyStimulus(BTN_D);
    checkOutput("start_dir_ignored", {aCurRow, aCurCol}, {3'd0, 3'd0});
    checkOutput("start_hold", aState, ST_START);
    applyStimulus(BTN_C);
    checkOutput("to_play", aState, ST_PLAY);
    applyStimulus(BTN_U);
    checkOutput("up_saturate", {aCurRow, aCurCol}, {3'd0, 3'd0});

    // Basic move: block (0,0); Up wins the d=2 tie against Left
    applyStimulus(BTN_C);
    checkOutput("basic_blocked", aBlocked, 64'h1);
    checkOutput("basic_moves", aMoves, 8'd1);
    checkOutput("basic_catmove", aState, ST_CATMOVE);
    checkOutput("basic_cat_hold", {aCatRow, aCatCol}, {3'd3, 3'd3});
    @(negedge clk);
    checkOutput("basic_cat", {aCatRow, aCatCol}, {3'd2, 3'd3});
    checkOutput("basic_state", aState, ST_PLAY);

    // Select with Right in the same cycle on a blocked cell: nothing happens
    applyStimulus(BTN_C | BTN_R);
    checkOutput("prio_cursor", {aCurRow, aCurCol}, {3'd0, 3'd0});
    checkOutput("prio_blocked", aBlocked, 64'h1);
    checkOutput("prio_moves", aMoves, 8'd1);
    checkOutput("prio_state", aState, ST_PLAY);

    // Chosen neighbour blocked: block (2,3), cat goes Left
    applyReset();
    applyStimulus(BTN_C);
    repeatStimulus(BTN_D, 2);
    repeatStimulus(BTN_R, 3);
    checkOutput("nb_cursor", {aCurRow, aCurCol}, {3'd2, 3'd3});
    applyStimulus(BTN_C);
    checkOutput("nb_blocked", aBlocked, 64'h1 << 19);
    checkOutput("nb_catmove", aState, ST_CATMOVE);
    @(negedge clk);
    checkOutput("nb_cat", {aCatRow, aCatCol}, {3'd3, 3'd2});
    checkOutput("nb_state", aState, ST_PLAY);

    // Select on an already-blocked cell, then on the cat cell
    applyStimulus(BTN_C);
    checkOutput("dup_blocked", aBlocked, 64'h1 << 19);
    checkOutput("dup_moves", aMoves, 8'd1);
    applyStimulus(BTN_D);
    applyStimulus(BTN_L);
    checkOutput("cat_cursor", {aCurRow, aCurCol}, {3'd3, 3'd2});
    applyStimulus(BTN_C);
    checkOutput("oncat_blocked", aBlocked, 64'h1 << 19);
    checkOutput("oncat_moves", aMoves, 8'd1);
    checkOutput("oncat_state", aState, ST_PLAY);

    // Win: cat at (3,3) fenced on Up/Right/Down, player closes Left (3,2)
    applyReset();
    applyStimulus(BTN_C);
    repeatStimulus(BTN_D, 3);
    repeatStimulus(BTN_R, 2);
    applyStimulus(BTN_C);
    checkOutput("win_catmove", wState, ST_CATMOVE);
    checkOutput("win_blocked", wBlocked, INIT_W | (64'h1 << 26));
    @(negedge clk);
    checkOutput("win_state", wState, ST_GAMEWIN);
    checkOutput("win_cat", {wCatRow, wCatCol}, {3'd3, 3'd3});
    checkOutput("win_moves", wMoves, 8'd1);
    applyStimulus(BTN_U);
    checkOutput("win_hold_cursor", {wCurRow, wCurCol}, {3'd3, 3'd2});
    checkOutput("win_hold_state", wState, ST_GAMEWIN);

    // Loss: cat at (1,1), player blocks (7,7), cat steps Up to (0,1)
    applyReset();
    applyStimulus(BTN_C);
    repeatStimulus(BTN_D, 7);
    repeatStimulus(BTN_R, 7);
    checkOutput("loss_cursor", {lCurRow, lCurCol}, {3'd7, 3'd7});
    applyStimulus(BTN_D);
    applyStimulus(BTN_R);
    checkOutput("loss_cursor_sat", {lCurRow, lCurCol}, {3'd7, 3'd7});
    applyStimulus(BTN_C);
    checkOutput("loss_blocked", lBlocked, 64'h1 << 63);
    checkOutput("loss_catmove", lState, ST_CATMOVE);
    @(negedge clk);
    checkOutput("loss_cat", {lCatRow, lCatCol}, {3'd0, 3'd1});
    checkOutput("loss_state", lState, ST_GAMEOVER);
    applyStimulus(BTN_U);
    checkOutput("loss_hold_cursor", {lCurRow, lCurCol}, {3'd7, 3'd7});
    applyStimulus(BTN_C);
    checkOutput("restart_state", lState, ST_START);
    checkOutput("restart_blocked", lBlocked, 64'h0);
    checkOutput("restart_cat", {lCatRow, lCatCol}, {3'd1, 3'd1});
    checkOutput("restart_cursor", {lCurRow, lCurCol}, {3'd0, 3'd0});
    checkOutput("restart_moves", lMoves, 8'd0);

    // Reset asserted during the CAT_MOVE cycle
    applyReset();
    applyStimulus(BTN_C);
    applyStimulus(BTN_C);
    checkOutput("midrst_catmove", aState, ST_CATMOVE);
    reset = 1'b1;
    #1;
    checkOutput("midrst_state", aState, ST_START);
    checkOutput("midrst_blocked", aBlocked, 64'h0);
    checkOutput("midrst_cat", {aCatRow, aCatCol}, {3'd3, 3'd3});
    checkOutput("midrst_moves", aMoves, 8'd0);
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    checkOutput("midrst_after_state", aState, ST_START);
    checkOutput("midrst_after_cat", {aCatRow, aCatCol}, {3'd3, 3'd3});

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
